// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_xcvr transceiver.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HI
  } rx_state_t;

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter with synchronous clear; flags the
// last cycle of a bit period and the mid-bit sampling point.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick_full,
  output logic tick_half
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   cnt <= '0;
    else if (clr || cnt == LAST) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

  assign tick_full = (cnt == LAST);
  assign tick_half = (cnt == HALF);

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with TX valid/ready handshake and a
// one-entry RX holding register. Define UART_PARITY_EN to add a parity bit.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_overrun,
  output logic              rx_parity_err
);

  localparam int BCW = bit_cnt_w(DATA_W);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  tx_state_t         tx_state, tx_state_d;
  logic [BCW-1:0]    tx_bit, tx_bit_d;
  logic [DATA_W-1:0] tx_shift, tx_shift_d;
  logic              tx_load, tx_shift_en, tx_tick, tx_half_unused;
  logic              txd_q, txd_d;
`ifdef UART_PARITY_EN
  logic              tx_par;
`endif

  rx_state_t         rx_state, rx_state_d;
  logic [BCW-1:0]    rx_bit, rx_bit_d;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_clr, rx_shift_en, rx_load, rx_full, rx_half;
  logic              rx_valid_d, frame_err_d, overrun_d;
  logic              rxd_meta, rxd_s;
`ifdef UART_PARITY_EN
  logic              rx_par_bad, rx_par_bad_d, parity_err_d, parity_err_q;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
    .clk(clk), .rstn(rstn), .clr(tx_load),
    .tick_full(tx_tick), .tick_half(tx_half_unused)
  );

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
    .clk(clk), .rstn(rstn), .clr(rx_clr),
    .tick_full(rx_full), .tick_half(rx_half)
  );

  assign tx_ready = (tx_state == TX_IDLE);
  assign txd      = txd_q;

  always_comb begin
    tx_state_d  = tx_state;
    tx_bit_d    = tx_bit;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    unique case (tx_state)
      TX_IDLE: if (tx_valid) begin
        tx_load    = 1'b1;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_tick) begin
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_tick) begin
        tx_shift_en = 1'b1;
        if (tx_bit == DATA_LAST) begin
          tx_bit_d = '0;
`ifdef UART_PARITY_EN
          tx_state_d = TX_PARITY;
`else
          tx_state_d = TX_STOP;
`endif
        end else begin
          tx_bit_d = tx_bit + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_tick) begin
        tx_bit_d   = '0;
        tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: if (tx_tick) begin
        if (tx_bit == STOP_LAST) tx_state_d = TX_IDLE;
        else                     tx_bit_d   = tx_bit + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    tx_shift_d = tx_load ? tx_data : (tx_shift_en ? (tx_shift >> 1) : tx_shift);

    // txd is registered from the next state so the pin never glitches
    unique case (tx_state_d)
      TX_START:  txd_d = START_LEVEL;
      TX_DATA:   txd_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      TX_PARITY: txd_d = tx_par;
`endif
      default:   txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_bit   <= '0;
      txd_q    <= IDLE_LEVEL;
    end else begin
      tx_state <= tx_state_d;
      tx_bit   <= tx_bit_d;
      txd_q    <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_d;
`ifdef UART_PARITY_EN
    if (tx_load) tx_par <= (^tx_data) ^ PAR_ODD;
`endif
    if (rx_shift_en) rx_shift <= {rxd_s, rx_shift[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_meta <= IDLE_LEVEL;
      rxd_s    <= IDLE_LEVEL;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_comb begin
    rx_state_d  = rx_state;
    rx_bit_d    = rx_bit;
    rx_clr      = 1'b0;
    rx_shift_en = 1'b0;
    rx_load     = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_d = rx_par_bad;
    parity_err_d = 1'b0;
`endif
    unique case (rx_state)
      RX_IDLE: if (rxd_s == START_LEVEL) begin
        rx_clr     = 1'b1;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_half) begin
        // re-phase the counter so tick_full lands mid-bit from here on
        if (rxd_s == START_LEVEL) begin
          rx_clr     = 1'b1;
          rx_bit_d   = '0;
          rx_state_d = RX_DATA;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_DATA: if (rx_full) begin
        rx_shift_en = 1'b1;
        if (rx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
          rx_state_d = RX_PARITY;
`else
          rx_state_d = RX_STOP;
`endif
        end else begin
          rx_bit_d = rx_bit + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_full) begin
        rx_par_bad_d = rxd_s ^ (^rx_shift) ^ PAR_ODD;
        rx_state_d   = RX_STOP;
      end
`endif
      RX_STOP: if (rx_full) begin
        if (rxd_s == IDLE_LEVEL) begin
          rx_state_d = RX_IDLE;
          if (!rx_valid || rx_ready) rx_load   = 1'b1;
          else                       overrun_d = 1'b1;
`ifdef UART_PARITY_EN
          parity_err_d = rx_par_bad;
`endif
        end else begin
          frame_err_d = 1'b1;
          rx_state_d  = RX_WAIT_HI;
        end
      end
      RX_WAIT_HI: if (rxd_s == IDLE_LEVEL) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase

    if (rx_load)                    rx_valid_d = 1'b1;
    else if (rx_valid && rx_ready)  rx_valid_d = 1'b0;
    else                            rx_valid_d = rx_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state     <= RX_IDLE;
      rx_bit       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_state     <= rx_state_d;
      rx_bit       <= rx_bit_d;
      rx_valid     <= rx_valid_d;
      rx_frame_err <= frame_err_d;
      rx_overrun   <= overrun_d;
      if (rx_load) rx_data <= rx_shift;
`ifdef UART_PARITY_EN
      rx_par_bad   <= rx_par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

`ifdef UART_PARITY_EN
  assign rx_parity_err = parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule
